// File: rtl/cmac_arbiter_if.sv
// Requester-side bus of cmac_arbiter: two operand-request channels and two response-FIFO channels.
// The master modport is the requester side; the slave modport is the arbiter.
interface cmac_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0, req1;
    logic                  gnt0, gnt1;
    logic [DATA_WIDTH-1:0] a_re0, a_im0, b_re0, b_im0;
    logic [DATA_WIDTH-1:0] a_re1, a_im1, b_re1, b_im1;
    logic                  rsp_valid0, rsp_valid1;
    logic [DATA_WIDTH-1:0] rsp_re0, rsp_im0, rsp_re1, rsp_im1;
    logic                  rsp_ready0, rsp_ready1;

    modport master (
        output req0, req1, a_re0, a_im0, b_re0, b_im0, a_re1, a_im1, b_re1, b_im1,
        output rsp_ready0, rsp_ready1,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_re0, rsp_im0, rsp_re1, rsp_im1
    );

    modport slave (
        input  req0, req1, a_re0, a_im0, b_re0, b_im0, a_re1, a_im1, b_re1, b_im1,
        input  rsp_ready0, rsp_ready1,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_re0, rsp_im0, rsp_re1, rsp_im1
    );
endinterface

// File: rtl/cmac_arbiter.sv
// Two requesters share one 3-stage fixed-point complex multiplier; results return through
// per-requester FIFOs under credit flow control. Macro CMAC_ARB_FIXED_PRIO_EN: requester 0 always wins.
module cmac_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int RSP_DEPTH  = 4
) (
    input  logic          clock,
    input  logic          reset,
    cmac_arbiter_if.slave bus
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    function automatic logic [DATA_WIDTH-1:0] mul_q(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [DATA_WIDTH-1:0] y);
        logic signed [2*DATA_WIDTH-1:0] xs, ys, full;
        xs   = signed'({{DATA_WIDTH{x[DATA_WIDTH-1]}}, x});
        ys   = signed'({{DATA_WIDTH{y[DATA_WIDTH-1]}}, y});
        full = xs * ys;
        return full[FRAC_BITS+DATA_WIDTH-1:FRAC_BITS];
    endfunction

    logic [1:0]            req_s, rdy_s, elig_s, gnt_s, push_s, pop_s;
    logic [1:0]            infl_s [2];
    logic [DATA_WIDTH-1:0] a_re_s, a_im_s, b_re_s, b_im_s, sum_re_s, sum_im_s;
    logic [CW-1:0]         occ_q [2];
    logic [AW-1:0]         wr_q [2], rd_q [2];
    logic [DATA_WIDTH-1:0] mem_re_q [2][RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_im_q [2][RSP_DEPTH];
    logic                  s1_v_q, s1_t_q, s2_v_q, s2_t_q;
    logic [DATA_WIDTH-1:0] op_are_q, op_aim_q, op_bre_q, op_bim_q;
    logic [DATA_WIDTH-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

    assign req_s = {bus.req1, bus.req0};
    assign rdy_s = {bus.rsp_ready1, bus.rsp_ready0};

    // Credit check: queued plus in-flight results must leave room in the FIFO (registered state only).
    always_comb begin
        infl_s[0] = {1'b0, s1_v_q & ~s1_t_q} + {1'b0, s2_v_q & ~s2_t_q};
        infl_s[1] = {1'b0, s1_v_q &  s1_t_q} + {1'b0, s2_v_q &  s2_t_q};
        for (int n = 0; n < 2; n++) begin
            elig_s[n] = req_s[n] && ((occ_q[n] + CW'(infl_s[n])) < DEPTH_C);
            pop_s[n]  = rdy_s[n] && (occ_q[n] != {CW{1'b0}});
        end
        push_s = {s2_v_q & s2_t_q, s2_v_q & ~s2_t_q};
    end

`ifndef CMAC_ARB_FIXED_PRIO_EN
    logic rr_q;  // 1: requester 1 has priority on the next contended cycle

    // Round-robin pointer: favour whoever was not granted most recently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (gnt_s[1]) begin
            rr_q <= 1'b0;
        end else if (gnt_s[0]) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_q;
        end
    end
`endif

    // Grant selection; at most one requester per cycle.
    always_comb begin
        gnt_s = 2'b00;
        if (reset) begin
            gnt_s = 2'b00;
        end else if (elig_s == 2'b11) begin
`ifdef CMAC_ARB_FIXED_PRIO_EN
            gnt_s = 2'b01;
`else
            gnt_s = rr_q ? 2'b10 : 2'b01;
`endif
        end else begin
            gnt_s = elig_s;
        end
    end

    always_comb begin
        a_re_s = gnt_s[1] ? bus.a_re1 : bus.a_re0;
        a_im_s = gnt_s[1] ? bus.a_im1 : bus.a_im0;
        b_re_s = gnt_s[1] ? bus.b_re1 : bus.b_re0;
        b_im_s = gnt_s[1] ? bus.b_im1 : bus.b_im0;
    end

    // Stages 1 and 2: capture granted operands, then register the four partial products.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v_q   <= 1'b0;
            s1_t_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s2_t_q   <= 1'b0;
            op_are_q <= {DATA_WIDTH{1'b0}};
            op_aim_q <= {DATA_WIDTH{1'b0}};
            op_bre_q <= {DATA_WIDTH{1'b0}};
            op_bim_q <= {DATA_WIDTH{1'b0}};
            p_rr_q   <= {DATA_WIDTH{1'b0}};
            p_ii_q   <= {DATA_WIDTH{1'b0}};
            p_ri_q   <= {DATA_WIDTH{1'b0}};
            p_ir_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_v_q <= |gnt_s;
            s1_t_q <= gnt_s[1];
            s2_v_q <= s1_v_q;
            s2_t_q <= s1_t_q;
            if (|gnt_s) begin
                op_are_q <= a_re_s;
                op_aim_q <= a_im_s;
                op_bre_q <= b_re_s;
                op_bim_q <= b_im_s;
            end
            if (s1_v_q) begin
                p_rr_q <= mul_q(op_are_q, op_bre_q);
                p_ii_q <= mul_q(op_aim_q, op_bim_q);
                p_ri_q <= mul_q(op_are_q, op_bim_q);
                p_ir_q <= mul_q(op_aim_q, op_bre_q);
            end
        end
    end

    assign sum_re_s = p_rr_q - p_ii_q;
    assign sum_im_s = p_ri_q + p_ir_q;

    // Response FIFOs: written from stage 3 to the tagged requester, popped on ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                occ_q[n] <= {CW{1'b0}};
                wr_q[n]  <= {AW{1'b0}};
                rd_q[n]  <= {AW{1'b0}};
                for (int i = 0; i < RSP_DEPTH; i++) begin
                    mem_re_q[n][i] <= {DATA_WIDTH{1'b0}};
                    mem_im_q[n][i] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push_s[n]) begin
                    mem_re_q[n][wr_q[n]] <= sum_re_s;
                    mem_im_q[n][wr_q[n]] <= sum_im_s;
                    wr_q[n]              <= wr_q[n] + AW'(1);
                end
                if (pop_s[n]) begin
                    rd_q[n] <= rd_q[n] + AW'(1);
                end
                case ({push_s[n], pop_s[n]})
                    2'b10:   occ_q[n] <= occ_q[n] + CW'(1);
                    2'b01:   occ_q[n] <= occ_q[n] - CW'(1);
                    default: occ_q[n] <= occ_q[n];
                endcase
            end
        end
    end

    assign bus.gnt0       = gnt_s[0];
    assign bus.gnt1       = gnt_s[1];
    assign bus.rsp_valid0 = (occ_q[0] != {CW{1'b0}});
    assign bus.rsp_valid1 = (occ_q[1] != {CW{1'b0}});
    assign bus.rsp_re0    = mem_re_q[0][rd_q[0]];
    assign bus.rsp_im0    = mem_im_q[0][rd_q[0]];
    assign bus.rsp_re1    = mem_re_q[1][rd_q[1]];
    assign bus.rsp_im1    = mem_im_q[1][rd_q[1]];
endmodule
